instr_fetch_axi_master: RTL and testbench

// - Instruction-side AXI4 read master in the CPU wrapper; consumes the held/advanced fetch PC
//   and returns the fetched word. Produces instruction_stall, the stall the PC-hold logic consumes.
// - One outstanding single-beat read; fetched word is held while the CPU pipeline is stalled.

---
 rtl/axi_pkg.sv | 17 +
 rtl/instr_fetch_axi_master.sv | 132 +++++++++++++
 tb/tb_instr_fetch_axi_master.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the instruction-fetch FSM state type.
package axi_pkg;

   localparam int          ID_BITS    = 4;
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  BURST_INCR = 2'b01;
   localparam logic [2:0]  SIZE_WORD  = 3'b010;
   localparam logic [31:0] RV_NOP     = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      DONE = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_axi_master.sv
// Instruction-side AXI4 read master: one outstanding single-beat read per
// fetch, word held in DONE while the pipeline is stalled.
//
// Handshake: a transfer happens on a rising ACLK edge where VALID and READY
// are both high. ARVALID, once raised, stays high with a stable payload until
// ARREADY is seen; RREADY is high only in R, so R beats offered in any other
// state are not taken. A flush never retracts an AR or refuses a beat, it only
// marks the in-flight fetch so its returned data is thrown away.
module instr_fetch_axi_master #(
   parameter int                 DATA_SIZE = 32,
   parameter int                 ID_BITS   = 4,
   parameter logic [ID_BITS-1:0] MASTER_ID = 4'd0
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [DATA_SIZE-1:0]   pc_data,
   input  logic                   fetch_en,
   input  logic                   flush,
   input  logic                   cpu_stall,
   output logic [DATA_SIZE-1:0]   instruction,
   output logic                   instr_valid,
   output logic                   instruction_stall,
   output logic                   fetch_err,
   output logic [ID_BITS-1:0]     ARID,
   output logic [DATA_SIZE-1:0]   ARADDR,
   output logic [3:0]             ARLEN,
   output logic [2:0]             ARSIZE,
   output logic [1:0]             ARBURST,
   output logic                   ARVALID,
   input  logic                   ARREADY,
   input  logic [ID_BITS-1:0]     RID,
   input  logic [DATA_SIZE-1:0]   RDATA,
   input  logic [1:0]             RRESP,
   input  logic                   RLAST,
   input  logic                   RVALID,
   output logic                   RREADY,
   output axi_pkg::fetch_state_e  state_dbg
);
   import axi_pkg::*;

   fetch_state_e           state_q;
   logic [DATA_SIZE-1:2]   addr_q;
   logic [DATA_SIZE-1:0]   instr_q;
   logic                   arvalid_q;
   logic                   rready_q;
   logic                   valid_q;
   logic                   err_q;
   logic                   discard_q;
   logic                   beat_err;
   logic                   unused_ok;

   // Single-beat reads make RLAST redundant; fetches are word aligned.
   assign unused_ok = &{1'b0, RLAST, pc_data[1:0]};

   // A returned beat is bad if the slave flagged it or it is not ours.
   assign beat_err = (RRESP != RESP_OKAY) || (RID != MASTER_ID);

   // Fetch FSM with all handshake and result outputs registered.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         instr_q   <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // fetch_en beats a same-cycle flush: pc_data is already the target
               if (fetch_en) begin
                  addr_q    <= pc_data[DATA_SIZE-1:2];
                  arvalid_q <= 1'b1;
                  discard_q <= 1'b0;
                  state_q   <= AR;
               end
            end
            AR: begin
               if (flush) discard_q <= 1'b1;
               if (ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= R;
               end
            end
            R: begin
               if (RVALID) begin
                  rready_q  <= 1'b0;
                  discard_q <= 1'b0;
                  if (discard_q || flush) begin
                     state_q <= IDLE;
                  end else begin
                     instr_q <= beat_err ? DATA_SIZE'(RV_NOP) : RDATA;
                     err_q   <= beat_err;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end
               end else if (flush) begin
                  discard_q <= 1'b1;
               end
            end
            DONE: begin
               if (flush || !cpu_stall) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The PC must hold from the cycle a fetch is requested until data lands.
   assign instruction_stall = (state_q == AR) || (state_q == R) ||
                              ((state_q == IDLE) && fetch_en);

   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;
   assign ARID        = MASTER_ID;
   assign ARADDR      = {addr_q, 2'b00};
   assign ARLEN       = 4'd0;
   assign ARSIZE      = SIZE_WORD;
   assign ARBURST     = BURST_INCR;
   assign ARVALID     = arvalid_q;
   assign RREADY      = rready_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch_axi_master.sv
// Self-checking bench for instr_fetch_axi_master: directed vector table,
// randomized fetches against a transaction-level model, reset corner cases.
module tb_instr_fetch_axi_master;
   import axi_pkg::*;

   // flush_at: 0 none, 1 first AR cycle, 2 first R cycle, 3 with the R beat,
   //           4 together with fetch_en in IDLE, 5 in DONE (with cpu_stall)
   typedef struct {
      logic [31:0] pc;
      int          ar_dly;
      int          r_dly;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic [3:0]  rid;
      int          flush_at;
      int          stall_cyc;
      logic [31:0] exp_instr;
      logic        exp_valid;
      logic        exp_err;
   } vec_t;

   logic        ACLK;
   logic        ARESETn;
   logic [31:0] pc_data;
   logic        fetch_en;
   logic        flush;
   logic        cpu_stall;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        instruction_stall;
   logic        fetch_err;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;
   fetch_state_e state_dbg;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_instr;
   vec_t        tbl[12];

   instr_fetch_axi_master #(
      .DATA_SIZE(32), .ID_BITS(4), .MASTER_ID(4'd0)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .pc_data(pc_data), .fetch_en(fetch_en),
      .flush(flush), .cpu_stall(cpu_stall), .instruction(instruction),
      .instr_valid(instr_valid), .instruction_stall(instruction_stall),
      .fetch_err(fetch_err), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
      .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
      .RREADY(RREADY), .state_dbg(state_dbg)
   );

   // clock / watchdog
   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] pc, input int ar, input int r,
                               input logic [31:0] d, input logic [1:0] resp,
                               input logic [3:0] id, input int fa, input int sc,
                               input logic [31:0] ei, input logic ev, input logic ee);
      vec_t v;
      v.pc = pc; v.ar_dly = ar; v.r_dly = r; v.rdata = d; v.rresp = resp;
      v.rid = id; v.flush_at = fa; v.stall_cyc = sc;
      v.exp_instr = ei; v.exp_valid = ev; v.exp_err = ee;
      return v;
   endfunction

   // Transaction-level reference: what the fetch unit should present after the beat.
   function automatic vec_t model(input vec_t v, input logic [31:0] prev);
      vec_t o;
      logic bad;
      o = v;
      bad = (v.rresp != 2'b00) || (v.rid != 4'd0);
      if (v.flush_at >= 1 && v.flush_at <= 3) begin
         o.exp_instr = prev;
         o.exp_valid = 1'b0;
         o.exp_err   = 1'b0;
      end else begin
         o.exp_instr = bad ? 32'h0000_0013 : v.rdata;
         o.exp_valid = 1'b1;
         o.exp_err   = bad;
      end
      return o;
   endfunction

   // Driver plus AXI slave for one fetch; starts and ends in IDLE at a negedge.
   task automatic do_fetch(input vec_t v);
      int          cyc;
      logic [31:0] a_exp;
      a_exp     = {v.pc[31:2], 2'b00};
      pc_data   = v.pc;
      fetch_en  = 1'b1;
      flush     = (v.flush_at == 4);
      #1;
      chk("stall_on_request", instruction_stall, 1);
      @(negedge ACLK);
      cyc      = 1;
      fetch_en = 1'b0;
      flush    = 1'b0;
      pc_data  = $urandom();
      chk("arvalid_up", ARVALID, 1);
      chk("araddr", ARADDR, a_exp);
      chk("ar_const", {ARID, ARLEN, ARSIZE, ARBURST}, {4'd0, 4'd0, 3'b010, 2'b01});
      for (int i = 0; i < v.ar_dly; i++) begin
         ARREADY = 1'b0;
         RVALID  = 1'b1;               // stray beat must not be taken outside R
         RDATA   = $urandom();
         flush   = (v.flush_at == 1) && (i == 0);
         @(negedge ACLK);
         cyc++;
         chk("ar_hold_valid", ARVALID, 1);
         chk("ar_hold_addr", ARADDR, a_exp);
         chk("ar_stall", instruction_stall, 1);
         chk("no_rready_in_ar", RREADY, 0);
      end
      RVALID  = 1'b0;
      ARREADY = 1'b1;
      flush   = (v.flush_at == 1) && (v.ar_dly == 0);
      @(negedge ACLK);
      cyc++;
      ARREADY = 1'b0;
      flush   = 1'b0;
      chk("r_rready", RREADY, 1);
      chk("r_arvalid_low", ARVALID, 0);
      chk("r_stall", instruction_stall, 1);
      for (int i = 0; i < v.r_dly; i++) begin
         RVALID = 1'b0;
         flush  = (v.flush_at == 2) && (i == 0);
         @(negedge ACLK);
         cyc++;
         flush = 1'b0;
         chk("r_wait_rready", RREADY, 1);
         chk("r_wait_stall", instruction_stall, 1);
      end
      RVALID = 1'b1;
      RDATA  = v.rdata;
      RRESP  = v.rresp;
      RID    = v.rid;
      RLAST  = 1'b1;
      flush  = (v.flush_at == 3) || ((v.flush_at == 2) && (v.r_dly == 0));
      @(negedge ACLK);
      cyc++;
      RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RID = 4'd0; flush = 1'b0;
      chk("rready_dropped", RREADY, 0);
      chk("instr_valid", instr_valid, v.exp_valid);
      chk("instruction", instruction, v.exp_instr);
      chk("fetch_err", fetch_err, v.exp_err);
      chk("stall_after_beat", instruction_stall, 0);
      if (v.exp_valid) begin
         chk("latency", cyc, 3 + v.ar_dly + v.r_dly);
         if (v.flush_at == 5) begin
            cpu_stall = 1'b1;
            flush     = 1'b1;
            @(negedge ACLK);
            cpu_stall = 1'b0;
            flush     = 1'b0;
            chk("done_flush_valid", instr_valid, 0);
            chk("done_flush_arvalid", ARVALID, 0);
         end else begin
            for (int i = 0; i < v.stall_cyc; i++) begin
               cpu_stall = 1'b1;
               fetch_en  = 1'b1;
               pc_data   = $urandom();
               @(negedge ACLK);
               chk("hold_valid", instr_valid, 1);
               chk("hold_instr", instruction, v.exp_instr);
               chk("hold_err_pulse", fetch_err, 0);
               chk("hold_no_ar", ARVALID, 0);
            end
            cpu_stall = 1'b0;
            fetch_en  = 1'b0;
            @(negedge ACLK);
            chk("release_valid", instr_valid, 0);
            chk("release_err", fetch_err, 0);
            chk("release_no_ar", ARVALID, 0);
         end
      end
   endtask

   initial begin
      vec_t v;
      ARESETn = 1'b0; pc_data = '0; fetch_en = 1'b0; flush = 1'b0; cpu_stall = 1'b0;
      ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
      last_instr = 32'h0;

      //          pc            ar r  rdata         resp  id    fa sc exp_instr     v     e
      tbl[0]  = mk(32'h0000_0010, 0, 0, 32'h0010_0093, 2'b00, 4'd0, 0, 0, 32'h0010_0093, 1'b1, 1'b0);
      tbl[1]  = mk(32'h0000_0023, 5, 0, 32'h0020_0113, 2'b00, 4'd0, 0, 0, 32'h0020_0113, 1'b1, 1'b0);
      tbl[2]  = mk(32'h0000_0040, 0, 2, 32'h1234_5678, 2'b00, 4'd0, 0, 4, 32'h1234_5678, 1'b1, 1'b0);
      tbl[3]  = mk(32'h0000_0080, 0, 1, 32'hDEAD_BEEF, 2'b00, 4'd0, 2, 0, 32'h1234_5678, 1'b0, 1'b0);
      tbl[4]  = mk(32'h0000_0080, 0, 0, 32'h0030_0193, 2'b00, 4'd0, 0, 0, 32'h0030_0193, 1'b1, 1'b0);
      tbl[5]  = mk(32'h0000_0084, 0, 0, 32'hAAAA_5555, 2'b10, 4'd0, 0, 1, 32'h0000_0013, 1'b1, 1'b1);
      tbl[6]  = mk(32'h0000_0088, 1, 0, 32'h5555_AAAA, 2'b00, 4'd3, 0, 0, 32'h0000_0013, 1'b1, 1'b1);
      tbl[7]  = mk(32'h0000_008C, 2, 0, 32'h0BAD_0BAD, 2'b11, 4'd0, 1, 0, 32'h0000_0013, 1'b0, 1'b0);
      tbl[8]  = mk(32'h0000_0090, 0, 2, 32'hCAFE_F00D, 2'b00, 4'd0, 3, 0, 32'h0000_0013, 1'b0, 1'b0);
      tbl[9]  = mk(32'h0000_0100, 2, 3, 32'h0000_0297, 2'b00, 4'd0, 0, 2, 32'h0000_0297, 1'b1, 1'b0);
      tbl[10] = mk(32'h0000_0200, 0, 0, 32'h0040_0213, 2'b00, 4'd0, 4, 0, 32'h0040_0213, 1'b1, 1'b0);
      tbl[11] = mk(32'h0000_0204, 0, 1, 32'h0050_0293, 2'b00, 4'd0, 5, 0, 32'h0050_0293, 1'b1, 1'b0);

      // reset state
      repeat (2) @(negedge ACLK);
      chk("rst_arvalid", ARVALID, 0);
      chk("rst_rready", RREADY, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_err", fetch_err, 0);
      chk("rst_stall", instruction_stall, 0);
      chk("rst_araddr", ARADDR, 0);
      chk("rst_instr", instruction, 0);
      ARESETn = 1'b1;
      @(negedge ACLK);
      chk("idle_no_stall", instruction_stall, 0);

      // directed table
      for (int k = 0; k < 12; k++) begin
         do_fetch(tbl[k]);
         if (tbl[k].exp_valid) last_instr = tbl[k].exp_instr;
      end

      // reset while in R abandons the read
      pc_data  = 32'h0000_0300;
      fetch_en = 1'b1;
      @(negedge ACLK);
      fetch_en = 1'b0;
      ARREADY  = 1'b1;
      @(negedge ACLK);
      ARREADY  = 1'b0;
      chk("pre_rst_rready", RREADY, 1);
      #2 ARESETn = 1'b0;
      #1;
      chk("arst_rready", RREADY, 0);
      chk("arst_arvalid", ARVALID, 0);
      chk("arst_stall", instruction_stall, 0);
      chk("arst_valid", instr_valid, 0);
      chk("arst_err", fetch_err, 0);
      chk("arst_instr", instruction, 0);
      chk("arst_araddr", ARADDR, 0);
      @(negedge ACLK);
      ARESETn    = 1'b1;
      last_instr = 32'h0;
      @(negedge ACLK);
      v = model(mk(32'h0000_0304, 1, 1, 32'h0060_0313, 2'b00, 4'd0, 0, 1, 0, 0, 0), last_instr);
      do_fetch(v);
      if (v.exp_valid) last_instr = v.exp_instr;

      // randomized fetches against the model
      for (int k = 0; k < 40; k++) begin
         vec_t r;
         r.pc        = $urandom();
         r.ar_dly    = $urandom_range(0, 3);
         r.r_dly     = $urandom_range(0, 3);
         r.rdata     = $urandom();
         r.rresp     = ($urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
         r.rid       = ($urandom_range(0, 5) != 0) ? 4'd0 : 4'($urandom_range(1, 15));
         r.flush_at  = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 5);
         r.stall_cyc = $urandom_range(0, 3);
         v = model(r, last_instr);
         do_fetch(v);
         if (v.exp_valid) last_instr = v.exp_instr;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
